// File: rtl/round_pkg.sv
// Shared types and constants for the round scheduler and its slot bank.
package round_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShow,
    StPlay,
    StTally,
    StDone
  } state_e;

  typedef logic [3:0] letter_t;

  localparam int unsigned NUM_ALPH_DEF = 5;
  localparam int unsigned ROUNDS_DEF   = 4;
  localparam int unsigned PASS_MIN_DEF = 3;
  localparam int unsigned SCORE_MAX    = 255;
  // Wide enough to index up to 8 letters per round
  localparam int unsigned IDX_W        = 3;

  // Game total never wraps; it sticks at SCORE_MAX
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return (s > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : s[7:0];
  endfunction

endpackage

// File: rtl/round_slot_bank.sv
// Letter/valid storage for one round: indexed write, clear-all, lowest-index
// match-and-clear, plus any-valid and duplicate-detect flags.
module round_slot_bank import round_pkg::*; #(
  parameter int unsigned NUM_ALPH = NUM_ALPH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  letter_t          wr_sym,
  input  logic             clr_all,
  input  logic [IDX_W-1:0] rd_idx,
  output letter_t          rd_sym,
  input  letter_t          match_sym,
  input  logic             match_clr,
  output logic             match_found,
  output logic             remain_any,
  output logic             any_valid,
  output logic             dup
);

  letter_t             slot_q [NUM_ALPH];
  logic [NUM_ALPH-1:0] valid_q, valid_d;
  logic [NUM_ALPH-1:0] match_oh;

  // Lowest-index match wins: scan from the top so the lowest hit is written last
  always_comb begin
    match_oh = '0;
    for (int i = int'(NUM_ALPH) - 1; i >= 0; i--) begin
      if (valid_q[i] && (slot_q[i] == match_sym)) begin
        match_oh    = '0;
        match_oh[i] = 1'b1;
      end
    end
  end

  // Read mux, status flags and duplicate detect against the incoming letter
  always_comb begin
    rd_sym = '0;
    dup    = 1'b0;
    for (int i = 0; i < int'(NUM_ALPH); i++) begin
      if (rd_idx == IDX_W'(i)) rd_sym = slot_q[i];
      if (valid_q[i] && (slot_q[i] == wr_sym)) dup = 1'b1;
    end
    match_found = |match_oh;
    any_valid   = |valid_q;
    remain_any  = |(valid_q & ~match_oh);
  end

  // Next valid vector; write and match-clear never happen in the same state
  always_comb begin
    valid_d = valid_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(NUM_ALPH); i++) begin
        if (wr_idx == IDX_W'(i)) valid_d[i] = 1'b1;
      end
    end else if (match_clr) begin
      valid_d = valid_q & ~match_oh;
    end
  end

  // Slot storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(NUM_ALPH); i++) slot_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(NUM_ALPH); i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) slot_q[i] <= wr_sym;
      end
    end
  end

endmodule

// File: rtl/round_scheduler.sv
// Round-level sequencer for the trainer's game mode: fetch letters from the
// RNG, present each for one 2 s period, score player entries, tally.
// Optional build macro ROUND_DEDUP_EN: reject letters already held this round.
module round_scheduler import round_pkg::*; #(
  parameter int unsigned NUM_ALPH = NUM_ALPH_DEF,
  parameter int unsigned ROUNDS   = ROUNDS_DEF,
  parameter int unsigned PASS_MIN = PASS_MIN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       rng_req,
  input  logic       rng_ack,
  input  logic [3:0] rng_sym,
  output logic       show_en,
  output logic [3:0] show_sym,
  output logic       tmr_req,
  input  logic       tmr_done,
  output logic       gt_allow,
  input  logic       gt_stop,
  input  logic       ply_load,
  input  logic [3:0] ply_sym,
  output logic       hit,
  output logic       miss,
  output logic [1:0] round_idx,
  output logic [3:0] round_score,
  output logic [7:0] total_score,
  output logic       level_up,
  output logic       done
);

`ifdef ROUND_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_ALPH - 1);
  localparam logic [1:0]       LAST_R = 2'(ROUNDS - 1);
  localparam logic [3:0]       PASS   = 4'(PASS_MIN);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             rng_req_q, rng_req_d;
  logic             tmr_req_q, tmr_req_d;
  logic             hit_q, hit_d, miss_q, miss_d;
  logic [1:0]       round_idx_q, round_idx_d;
  logic [3:0]       score_q, score_d;
  logic [7:0]       total_q, total_d;

  logic    wr_en, clr_all, match_clr;
  logic    match_found, remain_any, any_valid, dup;
  letter_t rd_sym;

  round_slot_bank #(
    .NUM_ALPH (NUM_ALPH)
  ) u_slots (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (k_q),
    .wr_sym      (rng_sym),
    .clr_all     (clr_all),
    .rd_idx      (k_q),
    .rd_sym      (rd_sym),
    .match_sym   (ply_sym),
    .match_clr   (match_clr),
    .match_found (match_found),
    .remain_any  (remain_any),
    .any_valid   (any_valid),
    .dup         (dup)
  );

  // Next-state, counters, handshakes and scoring
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rng_req_d   = rng_req_q;
    tmr_req_d   = 1'b0;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    round_idx_d = round_idx_q;
    score_d     = score_q;
    total_d     = total_q;
    wr_en       = 1'b0;
    clr_all     = 1'b0;
    match_clr   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StFetch;
          k_d         = '0;
          round_idx_d = '0;
          score_d     = '0;
          total_d     = '0;
          clr_all     = 1'b1;
        end
      end
      StFetch: begin
        // Request goes low for a cycle after every ack
        if (!rng_req_q) begin
          rng_req_d = 1'b1;
        end else if (rng_ack) begin
          rng_req_d = 1'b0;
          if (!(DEDUP && dup)) begin
            wr_en = 1'b1;
            if (k_q == LAST_K) begin
              state_d   = StShow;
              k_d       = '0;
              tmr_req_d = 1'b1;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
      end
      StShow: begin
        if (tmr_done) begin
          if (k_q == LAST_K) begin
            state_d = StPlay;
            k_d     = '0;
          end else begin
            k_d       = k_q + 1'b1;
            tmr_req_d = 1'b1;
          end
        end
      end
      StPlay: begin
        if (ply_load) begin
          match_clr = 1'b1;
          if (match_found) begin
            hit_d   = 1'b1;
            score_d = score_q + 4'd1;
          end else begin
            miss_d = 1'b1;
          end
        end
        // Entry is scored on the same edge that leaves for TALLY
        if (gt_stop || !any_valid || (ply_load && match_found && !remain_any)) begin
          state_d = StTally;
        end
      end
      StTally: begin
        total_d = sat_add(total_q, score_q);
        score_d = '0;
        clr_all = 1'b1;
        k_d     = '0;
        if (round_idx_q == LAST_R) begin
          state_d = StDone;
        end else begin
          round_idx_d = round_idx_q + 2'd1;
          state_d     = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      rng_req_q   <= 1'b0;
      tmr_req_q   <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      round_idx_q <= '0;
      score_q     <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      rng_req_q   <= rng_req_d;
      tmr_req_q   <= tmr_req_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      round_idx_q <= round_idx_d;
      score_q     <= score_d;
      total_q     <= total_d;
    end
  end

  // Outputs decoded from state so they drop with the asynchronous reset
  always_comb begin
    rng_req     = rng_req_q;
    tmr_req     = tmr_req_q;
    show_en     = (state_q == StShow);
    show_sym    = show_en ? rd_sym : 4'd0;
    gt_allow    = (state_q == StPlay);
    hit         = hit_q;
    miss        = miss_q;
    round_idx   = round_idx_q;
    round_score = score_q;
    total_score = total_q;
    level_up    = (state_q == StTally) && (score_q >= PASS);
    done        = (state_q == StDone);
  end

endmodule

// File: tb/tb_round_scheduler.sv
// Self-checking bench for round_scheduler: directed rounds from the test plan
// plus randomized rounds, checked against a queue-based letter/score model.
module tb_round_scheduler;

  localparam int NA = 5;
  localparam int NR = 4;
  localparam int PM = 3;
`ifdef ROUND_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rng_req, rng_ack = 1'b0;
  logic [3:0] rng_sym = 4'd0;
  logic       show_en;
  logic [3:0] show_sym;
  logic       tmr_req, tmr_done = 1'b0;
  logic       gt_allow, gt_stop = 1'b0;
  logic       ply_load = 1'b0;
  logic [3:0] ply_sym = 4'd0;
  logic       hit, miss;
  logic [1:0] round_idx;
  logic [3:0] round_score;
  logic [7:0] total_score;
  logic       level_up, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: letters held this round, which are still unmatched, and the scores
  int exp_slots[$];
  bit exp_valid[$];
  int exp_score, exp_total, exp_round;

  round_scheduler #(
    .NUM_ALPH (NA),
    .ROUNDS   (NR),
    .PASS_MIN (PM)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .start       (start),
    .rng_req     (rng_req),
    .rng_ack     (rng_ack),
    .rng_sym     (rng_sym),
    .show_en     (show_en),
    .show_sym    (show_sym),
    .tmr_req     (tmr_req),
    .tmr_done    (tmr_done),
    .gt_allow    (gt_allow),
    .gt_stop     (gt_stop),
    .ply_load    (ply_load),
    .ply_sym     (ply_sym),
    .hit         (hit),
    .miss        (miss),
    .round_idx   (round_idx),
    .round_score (round_score),
    .total_score (total_score),
    .level_up    (level_up),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] all_outs();
    return {rng_req, show_en, show_sym, tmr_req, gt_allow, hit, miss, round_idx,
            round_score, total_score, level_up, done};
  endfunction

  task automatic begin_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_total = 0;
    exp_round = 0;
    exp_score = 0;
    n_checks++;
    if (rng_req !== 1'b0 || round_idx !== 2'd0 || total_score !== 8'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL game_start: req=%b round=%0d total=%0d done=%b required 0/0/0/0",
               rng_req, round_idx, total_score, done);
    end
  endtask

  // Feed RNG letters on request; dly < 0 picks a random ack delay per letter
  task automatic run_fetch(input int syms[$], input int dly);
    int w, d;
    bit seen;
    exp_slots.delete();
    exp_valid.delete();
    exp_score = 0;
    foreach (syms[i]) begin
      if (exp_slots.size() == NA) break;
      w = 0;
      while (rng_req !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      n_checks++;
      if (rng_req !== 1'b1) begin
        n_fail++;
        $display("FAIL fetch_req_timeout: rng_req=%b required 1", rng_req);
        return;
      end
      d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      repeat (d) tick();
      rng_sym = 4'(syms[i]);
      rng_ack = 1'b1;
      tick();
      rng_ack = 1'b0;
      rng_sym = 4'($urandom);
      n_checks++;
      if (rng_req !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_req_drop: rng_req=%b required 0", rng_req);
      end
      seen = 1'b0;
      foreach (exp_slots[j]) if (exp_slots[j] == syms[i]) seen = 1'b1;
      if (!(DEDUP && seen)) begin
        exp_slots.push_back(syms[i]);
        exp_valid.push_back(1'b1);
      end
    end
    n_checks++;
    if (show_en !== 1'b1 || exp_slots.size() != NA) begin
      n_fail++;
      $display("FAIL fetch_fill: show_en=%b letters=%0d required 1/%0d",
               show_en, exp_slots.size(), NA);
    end
  endtask

  task automatic run_show();
    int hold;
    for (int k = 0; k < NA; k++) begin
      n_checks++;
      if (show_en !== 1'b1 || show_sym !== 4'(exp_slots[k]) || tmr_req !== 1'b1) begin
        n_fail++;
        $display("FAIL show_first k=%0d: en=%b sym=%0d tmr_req=%b required 1/%0d/1",
                 k, show_en, show_sym, tmr_req, exp_slots[k]);
      end
      hold = int'($urandom_range(1, 3));
      repeat (hold) tick();
      n_checks++;
      if (show_sym !== 4'(exp_slots[k]) || tmr_req !== 1'b0) begin
        n_fail++;
        $display("FAIL show_hold k=%0d: sym=%0d tmr_req=%b required %0d/0",
                 k, show_sym, tmr_req, exp_slots[k]);
      end
      tmr_done = 1'b1;
      tick();
      tmr_done = 1'b0;
    end
    n_checks++;
    if (gt_allow !== 1'b1 || show_en !== 1'b0) begin
      n_fail++;
      $display("FAIL show_to_play: gt_allow=%b show_en=%b required 1/0", gt_allow, show_en);
    end
  endtask

  // Enter letters; gt_stop rides on entry stop_at, or comes alone after the list
  task automatic run_play(input int entries[$], input int stop_at);
    int idx, left;
    bit end_now;
    for (int i = 0; i < entries.size(); i++) begin
      repeat ($urandom_range(0, 1)) tick();
      ply_sym  = 4'(entries[i]);
      ply_load = 1'b1;
      gt_stop  = (i == stop_at);
      tick();
      ply_load = 1'b0;
      gt_stop  = 1'b0;
      idx = -1;
      foreach (exp_slots[j])
        if (idx < 0 && exp_valid[j] && exp_slots[j] == entries[i]) idx = j;
      if (idx >= 0) begin
        exp_valid[idx] = 1'b0;
        exp_score++;
      end
      left = 0;
      foreach (exp_valid[j]) if (exp_valid[j]) left++;
      n_checks++;
      if (hit !== (idx >= 0) || miss !== (idx < 0) || round_score !== 4'(exp_score)) begin
        n_fail++;
        $display("FAIL play_entry sym=%0d: hit=%b miss=%b score=%0d required %b/%b/%0d",
                 entries[i], hit, miss, round_score, idx >= 0, idx < 0, exp_score);
      end
      end_now = (i == stop_at) || (left == 0);
      n_checks++;
      if (gt_allow !== !end_now || (end_now && level_up !== (exp_score >= PM))) begin
        n_fail++;
        $display("FAIL play_window: gt_allow=%b level_up=%b required %b/%b",
                 gt_allow, level_up, !end_now, exp_score >= PM);
      end
      if (end_now) return;
    end
    gt_stop = 1'b1;
    tick();
    gt_stop = 1'b0;
    n_checks++;
    if (gt_allow !== 1'b0 || level_up !== (exp_score >= PM) || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL play_stop: gt_allow=%b level_up=%b hit=%b required 0/%b/0",
               gt_allow, level_up, hit, exp_score >= PM);
    end
  endtask

  // Called in the TALLY cycle; checks the state after the tally edge
  task automatic finish_round();
    tick();
    exp_total = (exp_total + exp_score > 255) ? 255 : exp_total + exp_score;
    exp_score = 0;
    n_checks++;
    if (total_score !== 8'(exp_total) || round_score !== 4'd0 || level_up !== 1'b0) begin
      n_fail++;
      $display("FAIL tally_total: total=%0d score=%0d level_up=%b required %0d/0/0",
               total_score, round_score, level_up, exp_total);
    end
    if (exp_round == NR - 1) begin
      n_checks++;
      if (done !== 1'b1 || rng_req !== 1'b0 || gt_allow !== 1'b0) begin
        n_fail++;
        $display("FAIL game_done: done=%b req=%b gt_allow=%b required 1/0/0",
                 done, rng_req, gt_allow);
      end
    end else begin
      exp_round++;
      n_checks++;
      if (round_idx !== 2'(exp_round) || done !== 1'b0 || rng_req !== 1'b0) begin
        n_fail++;
        $display("FAIL next_round: round=%0d done=%b req=%b required %0d/0/0",
                 round_idx, done, rng_req, exp_round);
      end
    end
  endtask

  task automatic rand_syms(output int q[$]);
    q.delete();
    for (int i = 0; i < 24; i++) q.push_back(int'($urandom_range(0, 15)));
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: outs=%h required 0", all_outs());
    end
    tick();
    rst_n = 1'b1;
    ply_sym  = 4'd3;
    ply_load = 1'b1;
    tmr_done = 1'b1;
    rng_ack  = 1'b1;
    tick();
    ply_load = 1'b0;
    tmr_done = 1'b0;
    rng_ack  = 1'b0;
    tick();
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL idle_ignores_inputs: outs=%h required 0", all_outs());
    end
  endtask

  task automatic test_directed_round();
    begin_game();
    run_fetch('{3, 7, 1, 9, 2}, 2);
    run_show();
    run_play('{7, 1, 4, 3, 2, 9}, -1);
    n_checks++;
    if (round_score !== 4'd5 || level_up !== 1'b1 || gt_allow !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_tally: score=%0d level_up=%b gt_allow=%b required 5/1/0",
               round_score, level_up, gt_allow);
    end
    finish_round();
    n_checks++;
    if (total_score !== 8'd5) begin
      n_fail++;
      $display("FAIL directed_total: total=%0d required 5", total_score);
    end
  endtask

  task automatic test_timeout_round();
    run_fetch('{3, 4, 5, 6, 10}, -1);
    run_show();
    run_play('{3, 8}, 1);
    n_checks++;
    if (round_score !== 4'd1 || level_up !== 1'b0 || miss !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_tally: score=%0d level_up=%b miss=%b required 1/0/1",
               round_score, level_up, miss);
    end
    finish_round();
  endtask

  task automatic test_duplicates();
    run_fetch('{5, 5, 6, 11, 12, 13}, -1);
    run_show();
    run_play('{5, 5}, 2);
    n_checks++;
    if (round_score !== (DEDUP ? 4'd1 : 4'd2)) begin
      n_fail++;
      $display("FAIL dup_score: score=%0d required %0d", round_score, DEDUP ? 1 : 2);
    end
    finish_round();
  endtask

  task automatic test_random_round();
    int syms[$];
    int ent[$];
    int n;
    rand_syms(syms);
    run_fetch(syms, -1);
    run_show();
    n = int'($urandom_range(1, 8));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) ent.push_back(exp_slots[$urandom_range(0, NA - 1)]);
      else ent.push_back(int'($urandom_range(0, 15)));
    end
    run_play(ent, int'($urandom_range(0, n)));
    finish_round();
  endtask

  task automatic test_full_game();
    int syms[$];
    int ent[$];
    int j, t;
    begin_game();
    for (int r = 0; r < NR; r++) begin
      rand_syms(syms);
      run_fetch(syms, -1);
      run_show();
      ent = exp_slots;
      for (int i = ent.size() - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = ent[i];
        ent[i] = ent[j];
        ent[j] = t;
      end
      run_play(ent, -1);
      finish_round();
    end
    n_checks++;
    if (total_score !== 8'(NA * NR) || done !== 1'b1) begin
      n_fail++;
      $display("FAIL full_game: total=%0d done=%b required %0d/1", total_score, done, NA * NR);
    end
  endtask

  task automatic test_start_ignored_and_reset();
    int syms[$];
    begin_game();
    rand_syms(syms);
    run_fetch(syms, -1);
    run_show();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (gt_allow !== 1'b1 || round_idx !== 2'd0 || rng_req !== 1'b0 || hit !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_play: gt_allow=%b round=%0d req=%b hit=%b required 1/0/0/0",
               gt_allow, round_idx, rng_req, hit);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL async_reset: outs=%h required 0", all_outs());
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: outs=%h required 0", all_outs());
    end
    begin_game();
    tick();
    n_checks++;
    if (rng_req !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_fetch: rng_req=%b required 1", rng_req);
    end
  endtask

  initial begin
    test_reset();
    test_directed_round();
    test_timeout_round();
    test_duplicates();
    test_random_round();
    test_full_game();
    test_start_ignored_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
